// File: rtl/inst_decode.sv
// inst_decode: RV32I decode stage with a two-entry skid buffer; INST_DECODE_ILLEGAL_EN enables the illegal-opcode check
module inst_decode #(
    parameter int C_PC_WIDTH = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  INST_VALID,
    input  logic [31:0]           INST,
    input  logic [C_PC_WIDTH-1:0] PC,
    output logic                  INST_READY,
    input  logic                  FLUSH,
    output logic                  D_VALID,
    input  logic                  D_READY,
    output logic [C_PC_WIDTH-1:0] D_PC,
    output logic [6:0]            D_OPCODE,
    output logic [2:0]            D_FUNCT3,
    output logic                  D_FUNCT7B5,
    output logic [4:0]            D_RS1,
    output logic [4:0]            D_RS2,
    output logic [4:0]            D_RD,
    output logic [31:0]           D_IMM,
    output logic                  D_RD_WE,
    output logic                  D_ILLEGAL
);
    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;
    typedef struct packed {
        logic [C_PC_WIDTH-1:0] pc;
        logic [6:0]            opcode;
        logic [2:0]            funct3;
        logic                  funct7b5;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
        logic [31:0]           imm;
        logic                  rd_we;
        logic                  illegal;
    } dec_t;
    state_t state, next_state;
    dec_t   dec, out_q, skid_q;
    logic   ready_q, accept, load_out, load_skid, drain_skid;
    logic [6:0] op;
    assign op = INST[6:0];
    // decode the incoming word into fields, immediate and flags
    always_comb begin
        dec.pc       = PC;
        dec.opcode   = op;
        dec.funct3   = INST[14:12];
        dec.funct7b5 = INST[30];
        dec.rs1      = INST[19:15];
        dec.rs2      = INST[24:20];
        dec.rd       = INST[11:7];
        dec.imm      = (op inside {7'b0010011, 7'b0000011, 7'b1100111}) ? {{20{INST[31]}}, INST[31:20]} :
                       (op == 7'b0100011) ? {{20{INST[31]}}, INST[31:25], INST[11:7]} :
                       (op == 7'b1100011) ? {{19{INST[31]}}, INST[31], INST[7], INST[30:25], INST[11:8], 1'b0} :
                       (op inside {7'b0110111, 7'b0010111}) ? {INST[31:12], 12'b0} :
                       (op == 7'b1101111) ? {{11{INST[31]}}, INST[31], INST[19:12], INST[20], INST[30:21], 1'b0} :
                       32'b0;
        dec.rd_we    = (op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
                                   7'b0010111, 7'b1101111, 7'b1100111}) && (INST[11:7] != 5'd0);
`ifdef INST_DECODE_ILLEGAL_EN
        dec.illegal  = (INST[1:0] != 2'b11) ||
                       !(op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111,
                                    7'b0010111, 7'b1101111, 7'b1100111, 7'b0001111, 7'b1110011});
`else
        dec.illegal  = 1'b0;
`endif
    end
    // handshake qualification and skid-buffer next state; an accept during FLUSH is dropped
    always_comb begin
        accept     = INST_VALID && ready_q && !FLUSH;
        load_out   = accept && (state == S_EMPTY || D_READY);
        load_skid  = accept && state == S_ONE && !D_READY;
        drain_skid = state == S_TWO && D_READY && !FLUSH;
        next_state = FLUSH ? S_EMPTY :
                     (state == S_EMPTY) ? (accept ? S_ONE : S_EMPTY) :
                     (state == S_ONE) ? (load_skid ? S_TWO : (!accept && D_READY) ? S_EMPTY : S_ONE) :
                     (D_READY ? S_ONE : S_TWO);
    end
    // state and registered ready, which is low only while both entries are full
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state   <= S_EMPTY;
            ready_q <= 1'b0;
        end else begin
            state   <= next_state;
            ready_q <= next_state != S_TWO;
        end
    end
    // output and skid data registers; the skid entry moves forward when the output drains
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (drain_skid) out_q <= skid_q;
            else if (load_out) out_q <= dec;
            if (load_skid) skid_q <= dec;
        end
    end
    assign INST_READY = ready_q;
    assign D_VALID    = state != S_EMPTY;
    assign D_PC       = out_q.pc;
    assign D_OPCODE   = out_q.opcode;
    assign D_FUNCT3   = out_q.funct3;
    assign D_FUNCT7B5 = out_q.funct7b5;
    assign D_RS1      = out_q.rs1;
    assign D_RS2      = out_q.rs2;
    assign D_RD       = out_q.rd;
    assign D_IMM      = out_q.imm;
    assign D_RD_WE    = out_q.rd_we;
    assign D_ILLEGAL  = out_q.illegal;
endmodule
